opb_ctr_bank_ctrl: RTL
======================

// Module: opb_ctr_bank_ctrl
// PURPOSE
//  Single-clock OPB slave hosting N_CTR event counters (gbe rx/tx overflow, bad-frame, etc.).
//  Sequences OPB read/clear transactions against the live counter bank.
//  Arbitrates per-cycle between user increment pulses and software clears.
//  Sits on the PPC OPB alongside the simulink2ppc register slaves; replaces N separate ctr+reg pairs.
// PARAMETERS
//  C_BASEADDR    32'h01008300  first byte address of window
//  C_HIGHADDR    32'h010083FF  last byte address of window
//  C_OPB_AWIDTH  32            OPB address width
//  C_OPB_DWIDTH  32            OPB data width
//  N_CTR         4             number of counters, 1..32
//  CTR_W         32            counter width, 1..32, zero-extended on read
// PORTS
//  OPB_Clk      in   1       sole clock
//  OPB_Rst_n    in   1       asynchronous, active-low reset
//  OPB_ABus     in   [0:31]  address, big-endian bit order
//  OPB_BE       in   [0:3]   byte enables
//  OPB_DBus     in   [0:31]  write data
//  OPB_RNW      in   1       1=read, 0=write
//  OPB_select   in   1       transfer in progress
//  OPB_seqAddr  in   1       sequential burst hint, accepted but ignored
//  Sl_DBus      out  [0:31]  read data, all-zero except in the ack cycle of a read
//  Sl_xferAck   out  1       one-cycle transfer acknowledge
//  Sl_errAck    out  1       tied 0
//  Sl_retry     out  1       tied 0
//  Sl_toutSup   out  1       tied 0
//  ctr_inc      in   N_CTR   per-counter increment strobe, one count per cycle high
//  ctr_sat      out  N_CTR   per-counter sticky flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, OPB_Rst_n=0): FSM=IDLE, all counters=0, ctr_sat=0, Sl_DBus=0, Sl_xferAck=0; clears mid-transfer.
//  Hit = OPB_select & (C_BASEADDR <= OPB_ABus <= C_HIGHADDR); word index k = (OPB_ABus-C_BASEADDR)>>2.
//  FSM states:
//   IDLE: on hit go ACK.
//   ACK: Sl_xferAck=1 for exactly one cycle; go HOLD.
//   HOLD: stay while OPB_select=1; return to IDLE when OPB_select=0.
//  Latency: hit sampled at edge n -> Sl_xferAck high in cycle n+1. No second ack without select deasserting.
//  Read, k<N_CTR: Sl_DBus = zero-extended counter k, sampled at edge n.
//  Read, k=N_CTR: Sl_DBus = ctr_sat mapped LSB-first ({..,ctr_sat}, bit 31 = ctr_sat[0]).
//  Read, other k: Sl_DBus = 0, still acked.
//  Write, k<N_CTR with any BE bit set: counter k and ctr_sat[k] cleared at edge n+1 (ack edge); data value ignored.
//  Write, k=N_CTR with OPB_DBus[31]=1 and OPB_BE[3]=1: clear all counters and flags; other writes acked, no effect.
//  Write with OPB_BE=4'b0000: acked, no effect.
//  Same-cycle clear and ctr_inc on a counter: clear wins, result 0 (that increment is dropped).
//  Counters without clear increment by 1 on every ctr_inc cycle, independently, any number simultaneously.
// CONFIGURATION
//  Macro CTR_SATURATE_EN:
//   defined: counter holds at 2^CTR_W-1; ctr_sat[k] set on the attempted increment past max.
//   undefined: counter wraps to 0; ctr_sat[k] set on the wrap (sticky overflow indicator).
//  In both cases ctr_sat[k] clears only on reset or a software clear.
// STRUCTURE
//  Package opb_ctr_bank_pkg holds:
//   FSM state typedef: IDLE, ACK, HOLD.
//   SAT_REG_OFS=N_CTR, GCLR_BIT=31.
//   Function for the word index.
//  Sub-module opb_ctr_cell: one CTR_W counter with inc/clr inputs, sat/wrap logic and ctr_sat flag.
//   Instantiated N_CTR times via generate.
//  Top holds the decode, the FSM and the read mux.
// TESTING
//  1. Reset release, no traffic -> all counters read 0; Sl_DBus=0 and Sl_xferAck=0 every idle cycle.
//  2. 5 pulses ctr_inc[2], then read 0x01008308 -> ack one cycle after select, Sl_DBus=5; select held 3 cycles -> exactly one ack.
//  3. CTR_W=4, 17 pulses on ctr_inc[0]:
//     with CTR_SATURATE_EN -> reads 15, ctr_sat[0]=1;
//     without -> reads 1, ctr_sat[0]=1.
//  4. Write 0x01008304 in the same cycle as ctr_inc[1] -> counter 1 reads 0, ctr_sat[1]=0.
//  5. Write 0x00000001 to 0x01008310 -> all counters and flags 0; read 0x01008380 -> 0, acked.
//  6. Assert OPB_Rst_n=0 during ACK -> Sl_xferAck drops immediately; FSM in IDLE; next read acked normally.

Source files
------------

// File: rtl/opb_ctr_bank_pkg.sv
// Shared types and helpers for the OPB counter bank slave.
package opb_ctr_bank_pkg;

    // Bus-side transfer sequencing states.
    typedef enum logic [1:0] {
        IDLE,
        ACK,
        HOLD
    } opb_state_e;

    // Global-clear bit in the flag word (big-endian numbering: bit 31 is the LSB).
    localparam int GCLR_BIT    = 31;
    // Byte lane carrying the global-clear bit (big-endian numbering: lane 3 is the LSB byte).
    localparam int GCLR_LANE   = 3;

    // The flag word sits directly after the last counter word.
    function automatic int sat_reg_ofs(input int n_ctr);
        return n_ctr;
    endfunction

    // Word index of a byte address inside the window.
    function automatic logic [31:0] word_index(input logic [31:0] addr,
                                               input logic [31:0] base);
        logic [31:0] ofs;
        ofs = addr - base;
        return {2'b00, ofs[31:2]};
    endfunction

endpackage

// File: rtl/opb_ctr_cell.sv
// One event counter with clear priority and a sticky overflow/saturation flag.
// Build option: define CTR_SATURATE_EN to hold at the maximum instead of wrapping.
module opb_ctr_cell #(
    parameter int CTR_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CTR_W-1:0] cnt,
    output logic             sat
);

    localparam logic [CTR_W-1:0] CNT_MAX = '1;

    // Count, clear (which beats a same-cycle increment), and flag the overflow.
    // NOTE: state is updated with <= so every flop samples pre-edge values; blocking
    //       assignments here would create order-dependent simulation/synthesis mismatches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            sat <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            sat <= 1'b0;
        end else if (inc) begin
            if (cnt == CNT_MAX) begin
`ifdef CTR_SATURATE_EN
                sat <= 1'b1;
`else
                cnt <= '0;
                sat <= 1'b1;
`endif
            end else begin
                cnt <= cnt + CTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/opb_ctr_bank_ctrl.sv
// OPB slave exposing N_CTR event counters plus a sticky-flag word.
// Word k<N_CTR reads counter k (write clears it); word N_CTR reads the flags
// (write with bit 31 set in lane 3 clears everything). Other words read 0.
// Build option: CTR_SATURATE_EN selects saturating counters (default wraps).
module opb_ctr_bank_ctrl
    import opb_ctr_bank_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h01008300,
    parameter logic [31:0] C_HIGHADDR   = 32'h010083FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter int          N_CTR        = 4,
    parameter int          CTR_W        = 32
) (
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst_n,
    input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
    input  logic [0:3]              OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
    input  logic                    OPB_RNW,
    input  logic                    OPB_select,
    input  logic                    OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
    output logic                    Sl_xferAck,
    output logic                    Sl_errAck,
    output logic                    Sl_retry,
    output logic                    Sl_toutSup,
    input  logic [N_CTR-1:0]        ctr_inc,
    output logic [N_CTR-1:0]        ctr_sat
);

    localparam int SAT_REG_OFS = sat_reg_ofs(N_CTR);

    opb_state_e              state_q, state_d;
    logic                    hit, load;
    logic [31:0]             addr, word_idx;
    logic [C_OPB_DWIDTH-1:0] rd_mux, rd_data_q;
    logic [N_CTR-1:0]        clr_mask, clr_q;
    logic [CTR_W-1:0]        cnt [N_CTR];
    logic                    unused_inputs;

    assign unused_inputs = &{1'b0, OPB_seqAddr, OPB_DBus};

    assign addr     = 32'(OPB_ABus);
    assign hit      = OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
    assign word_idx = word_index(addr, C_BASEADDR);

    assign Sl_DBus    = rd_data_q;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    // Counter bank; clear mask is only non-zero during the ack cycle.
    // NOTE: the counters are individual flops, not a RAM, so they take the async reset.
    for (genvar i = 0; i < N_CTR; i++) begin : g_ctr
        opb_ctr_cell #(.CTR_W(CTR_W)) u_cell (
            .clk   (OPB_Clk),
            .rst_n (OPB_Rst_n),
            .inc   (ctr_inc[i]),
            .clr   (clr_q[i]),
            .cnt   (cnt[i]),
            .sat   (ctr_sat[i])
        );
    end

    // Address decode: read mux value and per-counter clear request for this address.
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        rd_mux   = '0;
        clr_mask = '0;
        for (int i = 0; i < N_CTR; i++) begin
            if (word_idx == 32'(i)) begin
                rd_mux      = C_OPB_DWIDTH'(cnt[i]);
                clr_mask[i] = |OPB_BE;
            end
        end
        if (word_idx == 32'(SAT_REG_OFS)) begin
            rd_mux   = C_OPB_DWIDTH'(ctr_sat);
            clr_mask = {N_CTR{OPB_DBus[GCLR_BIT] & OPB_BE[GCLR_LANE]}};
        end
    end

    // FSM state register.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) state_q <= IDLE;
        else            state_q <= state_d;
    end

    // FSM next state and outputs: one ack per select assertion.
    always_comb begin
        state_d    = state_q;
        load       = 1'b0;
        Sl_xferAck = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hit) begin
                    load    = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                Sl_xferAck = 1'b1;
                state_d    = HOLD;
            end
            HOLD: begin
                if (!OPB_select) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture read data and clear request on the accepting edge; both live one cycle.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            rd_data_q <= '0;
            clr_q     <= '0;
        end else begin
            rd_data_q <= (load && OPB_RNW)  ? rd_mux   : '0;
            clr_q     <= (load && !OPB_RNW) ? clr_mask : '0;
        end
    end

endmodule
